// File: rtl/branch_resolve_queue.sv
// In-order tracker for in-flight conditional branches: allocated at dispatch, resolved out of
// order by tag, retired in program order to drive the gshare predictor update and fetch redirect.
module branch_resolve_queue #(
    parameter int DEPTH = 8,
    parameter int TAG_W = $clog2(DEPTH),
    parameter int PC_W  = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    // Allocation handshake: a branch transfers on a rising edge where alloc_valid && alloc_ready;
    // alloc_tag is the tag of that branch and is only meaningful in the transfer cycle.
    input  logic             alloc_valid,
    input  logic [PC_W-1:0]  alloc_pc,
    input  logic             alloc_pred,
    output logic             alloc_ready,
    output logic [TAG_W-1:0] alloc_tag,
    input  logic             res_valid,
    input  logic [TAG_W-1:0] res_tag,
    input  logic             res_taken,
    input  logic [PC_W-1:0]  res_target,
    output logic             upd_valid,
    output logic [PC_W-1:0]  upd_pc,
    output logic             upd_taken,
    output logic             mispredict,
    output logic [PC_W-1:0]  redirect_pc,
    output logic [TAG_W:0]   count
);

    logic [DEPTH-1:0] ent_valid;
    logic [DEPTH-1:0] ent_resolved;
    logic [DEPTH-1:0] ent_pred;
    logic [DEPTH-1:0] ent_taken;
    logic [PC_W-1:0]  ent_pc     [DEPTH];
    logic [PC_W-1:0]  ent_target [DEPTH];

    logic [TAG_W-1:0] head;
    logic [TAG_W-1:0] tail;
    logic [TAG_W:0]   count_q;

    logic commit_now;
    logic flush_now;
    logic alloc_fire;
    logic res_fire;

    // Retirement looks only at registered state, so a resolution reaches the head one cycle later.
    always_comb begin
        commit_now  = ent_valid[head] && ent_resolved[head];
        flush_now   = commit_now && (ent_taken[head] != ent_pred[head]);
        alloc_ready = (count_q < (TAG_W+1)'(DEPTH)) && !flush_now;
        alloc_fire  = alloc_valid && alloc_ready;
        res_fire    = res_valid && ent_valid[res_tag] && !ent_resolved[res_tag] && !flush_now;
        alloc_tag   = tail;
        count       = count_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ent_valid    <= '0;
            ent_resolved <= '0;
            ent_pred     <= '0;
            ent_taken    <= '0;
            head         <= '0;
            tail         <= '0;
            count_q      <= '0;
            upd_valid    <= 1'b0;
            upd_pc       <= '0;
            upd_taken    <= 1'b0;
            mispredict   <= 1'b0;
            redirect_pc  <= '0;
        end else begin
            upd_valid  <= commit_now;
            mispredict <= flush_now;
            if (commit_now) begin
                upd_pc      <= ent_pc[head];
                upd_taken   <= ent_taken[head];
                redirect_pc <= ent_taken[head] ? ent_target[head] : ent_pc[head] + PC_W'(4);
            end

            if (flush_now) begin
                // Everything younger than the mispredicted branch is wrong-path work.
                ent_valid    <= '0;
                ent_resolved <= '0;
                head         <= head + 1'b1;
                tail         <= head + 1'b1;
                count_q      <= '0;
            end else begin
                if (alloc_fire) begin
                    ent_valid[tail]    <= 1'b1;
                    ent_resolved[tail] <= 1'b0;
                    ent_pc[tail]       <= alloc_pc;
                    ent_pred[tail]     <= alloc_pred;
                    tail               <= tail + 1'b1;
                end
                if (res_fire) begin
                    ent_resolved[res_tag] <= 1'b1;
                    ent_taken[res_tag]    <= res_taken;
                    ent_target[res_tag]   <= res_target;
                end
                if (commit_now) begin
                    ent_valid[head]    <= 1'b0;
                    ent_resolved[head] <= 1'b0;
                    head               <= head + 1'b1;
                end
                if (alloc_fire && !commit_now)
                    count_q <= count_q + 1'b1;
                else if (!alloc_fire && commit_now)
                    count_q <= count_q - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Bench for branch_resolve_queue: a table of single-branch retirements plus hand-written
// sequences for ordering, full queue, flush and reset corners, checked by an update scoreboard.
module tb_branch_resolve_queue;

    localparam int DEPTH = 8;
    localparam int TAG_W = 3;
    localparam int PC_W  = 32;
    localparam int EW    = PC_W + 1 + 1 + PC_W;  // {pc, taken, mispredict, redirect}

    logic             clk;
    logic             rst_n;
    logic             alloc_valid;
    logic [PC_W-1:0]  alloc_pc;
    logic             alloc_pred;
    logic             alloc_ready;
    logic [TAG_W-1:0] alloc_tag;
    logic             res_valid;
    logic [TAG_W-1:0] res_tag;
    logic             res_taken;
    logic [PC_W-1:0]  res_target;
    logic             upd_valid;
    logic [PC_W-1:0]  upd_pc;
    logic             upd_taken;
    logic             mispredict;
    logic [PC_W-1:0]  redirect_pc;
    logic [TAG_W:0]   count;

    int checks = 0;
    int errors = 0;
    logic [EW-1:0] exp_q[$];

    branch_resolve_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W), .PC_W(PC_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .alloc_valid(alloc_valid), .alloc_pc(alloc_pc), .alloc_pred(alloc_pred),
        .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
        .res_valid(res_valid), .res_tag(res_tag), .res_taken(res_taken), .res_target(res_target),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .mispredict(mispredict), .redirect_pc(redirect_pc), .count(count)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        exp_q.delete();
        rst_n = 1'b1;
    endtask

    // driver tasks
    task automatic alloc(input logic [PC_W-1:0] pc, input logic pred, output logic [TAG_W-1:0] tag);
        @(negedge clk);
        alloc_valid = 1'b1;
        alloc_pc    = pc;
        alloc_pred  = pred;
        #1;
        chk("alloc_ready", 64'(alloc_ready), 64'd1);
        tag = alloc_tag;
        @(posedge clk);
        #1 alloc_valid = 1'b0;
    endtask

    task automatic resolve(input logic [TAG_W-1:0] tag, input logic taken, input logic [PC_W-1:0] tgt);
        @(negedge clk);
        res_valid  = 1'b1;
        res_tag    = tag;
        res_taken  = taken;
        res_target = tgt;
        @(posedge clk);
        #1 res_valid = 1'b0;
    endtask

    task automatic expect_upd(input logic [PC_W-1:0] pc, input logic taken, input logic mis,
                              input logic [PC_W-1:0] redir);
        exp_q.push_back({pc, taken, mis, redir});
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d updates outstanding, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // scoreboard
    always @(negedge clk) begin
        if (rst_n && upd_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_update: pc=0x%0h taken=%0b mis=%0b, expected none",
                         upd_pc, upd_taken, mispredict);
            end else begin
                logic [EW-1:0] e;
                e = exp_q.pop_front();
                if ({upd_pc, upd_taken, mispredict, redirect_pc} !== e) begin
                    errors++;
                    $display("FAIL update: got pc=0x%0h tk=%0b mis=%0b rd=0x%0h expected pc=0x%0h tk=%0b mis=%0b rd=0x%0h",
                             upd_pc, upd_taken, mispredict, redirect_pc,
                             e[EW-1 -: PC_W], e[PC_W+1], e[PC_W], e[PC_W-1:0]);
                end
            end
        end
    end

    typedef struct {
        logic [PC_W-1:0] pc;
        logic            pred;
        logic            taken;
        logic [PC_W-1:0] target;
        logic            exp_mis;
        logic [PC_W-1:0] exp_redir;
    } vec_t;

    vec_t vecs[5];

    initial begin
        logic [TAG_W-1:0] tag;

        vecs[0] = '{32'h0000_0100, 1'b1, 1'b1, 32'h0000_0180, 1'b0, 32'h0000_0180};
        vecs[1] = '{32'h0000_0104, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_0108};
        vecs[2] = '{32'h0000_0108, 1'b1, 1'b0, 32'h0000_0900, 1'b1, 32'h0000_010C};
        vecs[3] = '{32'h0000_010C, 1'b0, 1'b1, 32'h0000_0400, 1'b1, 32'h0000_0400};
        vecs[4] = '{32'hFFFF_FFFC, 1'b1, 1'b0, 32'h0000_0040, 1'b1, 32'h0000_0000};

        rst_n = 1'b0; alloc_valid = 1'b0; alloc_pc = '0; alloc_pred = 1'b0;
        res_valid = 1'b0; res_tag = '0; res_taken = 1'b0; res_target = '0;
        do_reset();
        #1;
        chk("rst_upd_valid", 64'(upd_valid), 64'd0);
        chk("rst_mispredict", 64'(mispredict), 64'd0);
        chk("rst_upd_pc", 64'(upd_pc), 64'd0);
        chk("rst_redirect", 64'(redirect_pc), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_alloc_ready", 64'(alloc_ready), 64'd1);
        chk("rst_alloc_tag", 64'(alloc_tag), 64'd0);

        // single branch, latency R -> R+2
        alloc(32'h100, 1'b1, tag);
        chk("t1_tag", 64'(tag), 64'd0);
        expect_upd(32'h100, 1'b1, 1'b0, 32'h180);
        resolve(tag, 1'b1, 32'h180);
        @(negedge clk);
        chk("t1_no_upd_r1", 64'(upd_valid), 64'd0);
        @(negedge clk);
        chk("t1_upd_r2", 64'(upd_valid), 64'd1);
        chk("t1_upd_pc", 64'(upd_pc), 64'h100);
        chk("t1_count", 64'(count), 64'd0);
        wait_drain();

        // table of single-branch retirements
        for (int i = 0; i < 5; i++) begin
            alloc(vecs[i].pc, vecs[i].pred, tag);
            expect_upd(vecs[i].pc, vecs[i].taken, vecs[i].exp_mis, vecs[i].exp_redir);
            resolve(tag, vecs[i].taken, vecs[i].target);
            wait_drain();
            chk("vec_count", 64'(count), 64'd0);
        end

        // out-of-order resolution, in-order retirement
        do_reset();
        alloc(32'h300, 1'b1, tag);
        alloc(32'h310, 1'b0, tag);
        alloc(32'h320, 1'b1, tag);
        expect_upd(32'h300, 1'b1, 1'b0, 32'h380);
        expect_upd(32'h310, 1'b0, 1'b0, 32'h314);
        expect_upd(32'h320, 1'b1, 1'b0, 32'h3a0);
        resolve(3'd2, 1'b1, 32'h3a0);
        repeat (2) begin
            @(negedge clk);
            chk("t2_hold", 64'(upd_valid), 64'd0);
        end
        resolve(3'd0, 1'b1, 32'h380);
        resolve(3'd1, 1'b0, 32'h0);
        @(negedge clk);
        chk("t2_pc0", 64'(upd_valid ? upd_pc : '1), 64'h300);
        @(negedge clk);
        chk("t2_pc1", 64'(upd_valid ? upd_pc : '1), 64'h310);
        @(negedge clk);
        chk("t2_pc2", 64'(upd_valid ? upd_pc : '1), 64'h320);
        wait_drain();

        // full queue and tag wrap
        do_reset();
        for (int i = 0; i < DEPTH; i++) alloc(32'h1000 + 32'(i * 4), 1'b1, tag);
        #1;
        chk("t3_count_full", 64'(count), 64'd8);
        chk("t3_ready_full", 64'(alloc_ready), 64'd0);
        @(negedge clk);
        alloc_valid = 1'b1;
        alloc_pc    = 32'hdead;
        @(posedge clk);
        #1 alloc_valid = 1'b0;
        chk("t3_ninth_rejected", 64'(count), 64'd8);
        expect_upd(32'h1000, 1'b1, 1'b0, 32'h2000);
        resolve(3'd0, 1'b1, 32'h2000);
        @(negedge clk);
        #1;
        chk("t3_no_bypass", 64'(alloc_ready), 64'd0);
        @(negedge clk);
        #1;
        chk("t3_count_after_retire", 64'(count), 64'd7);
        chk("t3_wrap_tag", 64'(alloc_tag), 64'd0);
        alloc(32'h2000, 1'b1, tag);
        chk("t3_alloc_tag0", 64'(tag), 64'd0);
        #1;
        chk("t3_count_refull", 64'(count), 64'd8);
        wait_drain();

        // not-taken mispredict squashes younger entries
        do_reset();
        alloc(32'h200, 1'b1, tag);
        alloc(32'h204, 1'b1, tag);
        alloc(32'h208, 1'b1, tag);
        alloc(32'h20c, 1'b1, tag);
        expect_upd(32'h200, 1'b0, 1'b1, 32'h204);
        resolve(3'd1, 1'b1, 32'h50);
        resolve(3'd2, 1'b1, 32'h60);
        resolve(3'd0, 1'b0, 32'h999);
        @(negedge clk);
        #1;
        chk("t4_flush_ready", 64'(alloc_ready), 64'd0);
        @(negedge clk);
        #1;
        chk("t4_mispredict", 64'(mispredict), 64'd1);
        chk("t4_redirect", 64'(redirect_pc), 64'h204);
        chk("t4_count", 64'(count), 64'd0);
        resolve(3'd3, 1'b1, 32'h70);
        repeat (5) @(negedge clk);
        chk("t4_count_idle", 64'(count), 64'd0);

        // taken mispredict; allocation attempted in the flush cycle
        alloc(32'h300, 1'b0, tag);
        chk("t5_tag_after_flush", 64'(tag), 64'd1);
        expect_upd(32'h300, 1'b1, 1'b1, 32'h400);
        resolve(tag, 1'b1, 32'h400);
        @(negedge clk);
        alloc_valid = 1'b1;
        alloc_pc    = 32'hbeef;
        #1;
        chk("t5_flush_ready", 64'(alloc_ready), 64'd0);
        @(posedge clk);
        #1 alloc_valid = 1'b0;
        @(negedge clk);
        #1;
        chk("t5_redirect", 64'(redirect_pc), 64'h400);
        chk("t5_count", 64'(count), 64'd0);
        chk("t5_tail", 64'(alloc_tag), 64'd2);
        wait_drain();

        // ignored resolutions, then reset mid-stream
        do_reset();
        alloc(32'h500, 1'b1, tag);
        alloc(32'h504, 1'b1, tag);
        resolve(3'd5, 1'b1, 32'h10);
        resolve(3'd1, 1'b1, 32'h600);
        resolve(3'd1, 1'b0, 32'h0);
        repeat (2) begin
            @(negedge clk);
            chk("t6_no_upd", 64'(upd_valid), 64'd0);
        end
        chk("t6_count", 64'(count), 64'd2);
        expect_upd(32'h500, 1'b1, 1'b0, 32'h700);
        expect_upd(32'h504, 1'b1, 1'b0, 32'h600);
        resolve(3'd0, 1'b1, 32'h700);
        wait_drain();
        alloc(32'h800, 1'b1, tag);
        resolve(tag, 1'b1, 32'h880);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("t6_rst_no_upd", 64'(upd_valid), 64'd0);
        end
        chk("t6_rst_count", 64'(count), 64'd0);
        wait_drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
